// File: rtl/byte_xform_arbiter_pkg.sv
// Shared types for the byte transform arbiter: operand/result bytes,
// requester index width and FSM state encoding.
typedef logic [7:0] x_t;

package byte_xform_arbiter_pkg;

    typedef logic [7:0] y_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef logic [IDX_W-1:0] req_idx_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        RESP  = S_RESP
    } arb_state_t;

    // Round-robin successor of idx among num_req requesters.
    function automatic req_idx_t next_idx(input req_idx_t idx, input int num_req);
        if (int'(idx) >= num_req - 1) begin
            return '0;
        end
        return idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/byte_xform_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker
    import byte_xform_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
)
(
    input  logic [NUM_REQ-1:0] valid,
    input  req_idx_t           ptr,
    output req_idx_t           grant,
    output logic               any_valid
);

    req_idx_t           cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;

    // Candidate gi is the requester gi places after ptr in round-robin order.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        logic [IDX_W:0] wrapped;

        assign sum           = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign wrapped       = (sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum;
        assign cand_idx[gi]  = wrapped[IDX_W-1:0];
        assign cand_valid[gi] = |(valid & (NUM_REQ'(1) << wrapped));
    end

    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant = cand_idx[i];
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/byte_xform_arbiter.sv
// Round-robin arbiter sharing one byte transform unit among NUM_REQ requesters,
// one transaction in flight, with a done timeout.
module byte_xform_arbiter
    import byte_xform_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  x_t                 req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_valid,
    output y_t                 rsp_data,
    output logic               rsp_err,
    output logic               unit_start,
    output x_t                 unit_x,
    input  logic               unit_done,
    input  y_t                 unit_y
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    arb_state_t state_reg, state_next;
    req_idx_t   rr_ptr_reg, rr_ptr_next;
    req_idx_t   grant_reg, grant_next;
    x_t         data_reg, data_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    y_t         result_reg, result_next;
    logic       err_reg, err_next;

    req_idx_t pick_idx;
    logic     pick_any;
    x_t       pick_data;
    logic     ready_en;
    logic     handshake;

    rr_picker #(
        .NUM_REQ   (NUM_REQ)
    ) u_picker (
        .valid     (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (pick_idx),
        .any_valid (pick_any)
    );

    // Ready is held low while reset is asserted even though the state is IDLE.
    assign ready_en  = rst_n && (state_reg == IDLE) && pick_any;
    assign handshake = |(req_valid & req_ready);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign req_ready[gi] = ready_en && (pick_idx == req_idx_t'(gi));
        assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == req_idx_t'(gi));
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == req_idx_t'(i)) begin
                pick_data = req_data[i];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_next    = grant_reg;
        data_next     = data_reg;
        wait_cnt_next = wait_cnt_reg;
        result_next   = result_reg;
        err_next      = err_reg;
        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    data_next     = pick_data;
                    grant_next    = pick_idx;
                    wait_cnt_next = '0;
                    state_next    = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                // A done arriving on the last allowed cycle beats the timeout.
                if (unit_done) begin
                    result_next = unit_y;
                    err_next    = 1'b0;
                    state_next  = RESP;
                end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    result_next   = '0;
                    err_next      = 1'b1;
                    state_next    = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    state_next    = WAIT;
                end
            end
            RESP: begin
                rr_ptr_next = next_idx(grant_reg, NUM_REQ);
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            data_reg     <= '0;
            wait_cnt_reg <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_reg    <= grant_next;
            data_reg     <= data_next;
            wait_cnt_reg <= wait_cnt_next;
            result_reg   <= result_next;
            err_reg      <= err_next;
        end
    end

    assign unit_start = (state_reg == ISSUE);
    assign unit_x     = data_reg;
    assign rsp_data   = (state_reg == RESP) ? result_reg : '0;
    assign rsp_err    = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_byte_xform_arbiter.sv
// Randomized bench for byte_xform_arbiter against a round-robin/inverter model.
module tb_byte_xform_arbiter;
    import byte_xform_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    x_t           req_data [N];
    logic [N-1:0] rsp_valid;
    y_t           rsp_data;
    logic         rsp_err;
    logic         unit_start;
    x_t           unit_x;
    logic         unit_done;
    y_t           unit_y;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int model_ptr = 0;

    int   unit_delay = 0;
    bit   unit_en    = 1'b1;
    bit   model_pend = 1'b0;
    int   model_cnt  = 0;
    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    y_t   model_y    = '0;

    assign unit_done = model_done | spur_done;
    assign unit_y    = model_y;

    byte_xform_arbiter #(
        .NUM_REQ    (N),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .unit_start (unit_start),
        .unit_x     (unit_x),
        .unit_done  (unit_done),
        .unit_y     (unit_y)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Transform unit: y = ~x, done unit_delay cycles after the start cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            model_done = 1'b0;
            if (unit_start) begin
                model_pend = 1'b1;
                model_cnt  = 0;
            end
            if (model_pend && unit_en && model_cnt == unit_delay) begin
                model_done = 1'b1;
                model_y    = ~unit_x;
                model_pend = 1'b0;
            end else if (model_pend) begin
                model_cnt = model_cnt + 1;
            end
        end
    end

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    // Observes one transaction from handshake to response; makes no judgement.
    task automatic run_txn(input bit drop, output int hs_idx, output int rdy_cnt,
                           output int lat_start, output int lat_rsp, output x_t ux,
                           output logic [N-1:0] rv, output y_t rd, output logic re,
                           output int ready_viol, output bit to);
        int  hs_cyc;
        bit  found;
        hs_idx = -1; rdy_cnt = 0; lat_start = -1; lat_rsp = -1; ux = '0;
        rv = '0; rd = '0; re = 1'b0; ready_viol = 0; to = 1'b0; hs_cyc = 0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                found   = 1'b1;
                hs_cyc  = cyc;
                hs_idx  = first_set(req_valid & req_ready);
                rdy_cnt = $countones(req_ready);
            end
        end
        if (!found) begin
            to = 1'b1;
            return;
        end
        if (drop) begin
            drive_slot();
            req_valid[hs_idx] = 1'b0;
        end
        found = 1'b0;
        for (int k = 0; k < TO + 40 && !found; k++) begin
            @(negedge clk);
            if (req_ready != '0) ready_viol++;
            if (unit_start && lat_start < 0) begin
                lat_start = cyc - hs_cyc;
                ux        = unit_x;
            end
            if (rsp_valid != '0) begin
                rv      = rsp_valid;
                rd      = rsp_data;
                re      = rsp_err;
                lat_rsp = cyc - hs_cyc;
                found   = 1'b1;
            end
        end
        if (!found) to = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i] = x_t'(8'h10 + i);
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || unit_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b start=%b want 0", req_ready, rsp_valid, unit_start);
        end
        checks++;
        if (rsp_data !== 8'h00 || rsp_err !== 1'b0 || unit_x !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: rsp_data=%h err=%b unit_x=%h want 0", rsp_data, rsp_err, unit_x);
        end
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || unit_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: ready=%b rsp_valid=%b start=%b want 0", req_ready, rsp_valid, unit_start);
        end
        model_ptr = 0;
        $display("test_reset done");
    endtask

    task automatic test_all_valid();
        int hs, rc, ls, lr, vio, exp;
        x_t ux; logic [N-1:0] rv; y_t rd, ey; logic re; bit to;
        drive_slot();
        for (int i = 0; i < N; i++) req_data[i] = x_t'(i);
        req_valid  = '1;
        unit_delay = 0;
        for (int n = 0; n < 5; n++) begin
            exp = model_pick(4'b1111, model_ptr);
            ey  = ~req_data[exp];
            run_txn(1'b0, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
            $display("all_valid txn %0d: grant=%0d rsp=%h err=%b lat=%0d", n, hs, rd, re, lr);
            checks++;
            if (to || hs !== exp) begin
                errors++;
                $display("FAIL all_valid_grant: got %0d want %0d (to=%0d)", hs, exp, to);
            end
            checks++;
            if (rd !== ey || re !== 1'b0 || rv !== N'(1 << exp)) begin
                errors++;
                $display("FAIL all_valid_rsp: data=%h err=%b rv=%b want %h 0 %b", rd, re, rv, ey, N'(1 << exp));
            end
            checks++;
            if (ls !== 1 || lr !== 2 || vio !== 0 || rc !== 1) begin
                errors++;
                $display("FAIL all_valid_timing: start=%0d rsp=%0d viol=%0d rdy=%0d want 1 2 0 1", ls, lr, vio, rc);
            end
            model_ptr = (exp + 1) % N;
        end
        drive_slot();
        req_valid = '0;
    endtask

    task automatic test_single();
        int hs, rc, ls, lr, vio;
        x_t ux; logic [N-1:0] rv; y_t rd; logic re; bit to;
        drive_slot();
        req_data[1] = 8'h3C;
        req_valid   = 4'b0010;
        unit_delay  = 0;
        run_txn(1'b1, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
        $display("single: grant=%0d start=%0d rsp_lat=%0d rv=%b data=%h err=%b", hs, ls, lr, rv, rd, re);
        checks++;
        if (to || ls !== 1 || ux !== 8'h3C) begin
            errors++;
            $display("FAIL single_start: lat=%0d unit_x=%h want 1 3c", ls, ux);
        end
        checks++;
        if (lr !== 2 || rv !== 4'b0010 || rd !== 8'hC3 || re !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: lat=%0d rv=%b data=%h err=%b want 2 0010 c3 0", lr, rv, rd, re);
        end
        model_ptr = 2;
    endtask

    task automatic test_timeout();
        int hs, rc, ls, lr, vio, exp;
        x_t ux; logic [N-1:0] rv; y_t rd; logic re; bit to;
        drive_slot();
        unit_en     = 1'b0;
        req_data[3] = 8'hA5;
        req_valid   = 4'b1000;
        exp = model_pick(4'b1000, model_ptr);
        run_txn(1'b1, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
        $display("timeout: grant=%0d rsp_after_start=%0d data=%h err=%b", hs, lr - ls, rd, re);
        checks++;
        if (to || re !== 1'b1 || rd !== 8'h00 || rv !== N'(1 << exp)) begin
            errors++;
            $display("FAIL timeout_rsp: err=%b data=%h rv=%b want 1 00 %b", re, rd, rv, N'(1 << exp));
        end
        checks++;
        if (lr - ls !== TO || vio !== 0) begin
            errors++;
            $display("FAIL timeout_latency: got %0d viol=%0d want %0d 0", lr - ls, vio, TO);
        end
        model_ptr = (exp + 1) % N;
        drive_slot();
        model_pend  = 1'b0;
        unit_en     = 1'b1;
        unit_delay  = 2;
        req_data[0] = 8'h5A;
        req_valid   = 4'b0001;
        run_txn(1'b1, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
        $display("after_timeout: grant=%0d data=%h err=%b lat=%0d", hs, rd, re, lr);
        checks++;
        if (to || hs !== 0 || rd !== 8'hA5 || re !== 1'b0 || lr !== 4) begin
            errors++;
            $display("FAIL after_timeout: grant=%0d data=%h err=%b lat=%0d want 0 a5 0 4", hs, rd, re, lr);
        end
        model_ptr = 1;
    endtask

    task automatic test_done_at_timeout();
        int hs, rc, ls, lr, vio, extra;
        x_t ux; logic [N-1:0] rv; y_t rd; logic re; bit to;
        drive_slot();
        unit_delay  = TO - 1;
        req_data[2] = 8'h81;
        req_valid   = 4'b0100;
        run_txn(1'b1, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
        $display("done_at_timeout: data=%h err=%b rsp_after_start=%0d", rd, re, lr - ls);
        checks++;
        if (to || re !== 1'b0 || rd !== 8'h7E || lr - ls !== TO) begin
            errors++;
            $display("FAIL done_at_timeout: err=%b data=%h lat=%0d want 0 7e %0d", re, rd, lr - ls, TO);
        end
        model_ptr = 3;
        drive_slot();
        unit_delay  = TO;
        req_data[3] = 8'h42;
        req_valid   = 4'b1000;
        run_txn(1'b1, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
        $display("done_after_timeout: data=%h err=%b rsp_after_start=%0d", rd, re, lr - ls);
        checks++;
        if (to || re !== 1'b1 || rd !== 8'h00 || lr - ls !== TO) begin
            errors++;
            $display("FAIL done_after_timeout: err=%b data=%h lat=%0d want 1 00 %0d", re, rd, lr - ls, TO);
        end
        model_ptr = 0;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid != '0 || unit_start) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL late_done_in_resp: activity cycles=%0d want 0", extra);
        end
        model_pend = 1'b0;
    endtask

    task automatic test_spurious_done();
        int hs, rc, ls, lr, vio, act, exp;
        x_t ux; logic [N-1:0] rv; y_t rd, ey; logic re; bit to;
        drive_slot();
        spur_done = 1'b1;
        act = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != '0 || unit_start || req_ready != '0) act++;
        end
        drive_slot();
        spur_done = 1'b0;
        $display("spurious_done: activity cycles=%0d", act);
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL spurious_done: activity cycles=%0d want 0", act);
        end
        unit_delay = 1;
        req_data[1] = 8'hF0; req_data[2] = 8'h0F;
        req_valid   = 4'b0110;
        exp = model_pick(4'b0110, model_ptr);
        ey  = ~req_data[exp];
        run_txn(1'b1, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
        checks++;
        if (to || hs !== exp || rd !== ey || lr !== 3) begin
            errors++;
            $display("FAIL after_spurious: grant=%0d data=%h lat=%0d want %0d %h 3", hs, rd, lr, exp, ey);
        end
        model_ptr = (exp + 1) % N;
        drive_slot();
        req_valid = '0;
    endtask

    task automatic test_random();
        int hs, rc, ls, lr, vio, exp, dly;
        x_t ux; logic [N-1:0] rv, v; y_t rd, ey; logic re; bit to;
        for (int n = 0; n < 20; n++) begin
            drive_slot();
            v   = N'($urandom_range(1, (1 << N) - 1));
            dly = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) req_data[i] = x_t'($urandom);
            unit_delay = dly;
            req_valid  = v;
            exp = model_pick(v, model_ptr);
            ey  = ~req_data[exp];
            run_txn(1'b1, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
            $display("random %0d: valid=%b ptr=%0d grant=%0d delay=%0d rsp=%h err=%b lat=%0d",
                     n, v, model_ptr, hs, dly, rd, re, lr);
            checks++;
            if (to || hs !== exp || rc !== 1) begin
                errors++;
                $display("FAIL random_grant: got %0d rdy_bits=%0d want %0d 1", hs, rc, exp);
            end
            checks++;
            if (rd !== ey || re !== 1'b0 || rv !== N'(1 << exp)) begin
                errors++;
                $display("FAIL random_rsp: data=%h err=%b rv=%b want %h 0 %b", rd, re, rv, ey, N'(1 << exp));
            end
            checks++;
            if (ls !== 1 || lr !== 2 + dly || vio !== 0) begin
                errors++;
                $display("FAIL random_timing: start=%0d rsp=%0d viol=%0d want 1 %0d 0", ls, lr, vio, 2 + dly);
            end
            model_ptr = (exp + 1) % N;
        end
        drive_slot();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int hs, rc, ls, lr, vio, act;
        x_t ux; logic [N-1:0] rv; y_t rd; logic re; bit to, found;
        drive_slot();
        unit_en     = 1'b0;
        req_data[1] = 8'h77;
        req_valid   = 4'b0010;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_handshake: no handshake within bound");
        end
        drive_slot();
        req_valid = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        $display("reset_mid: ready=%b rsp_valid=%b data=%h err=%b start=%b unit_x=%h",
                 req_ready, rsp_valid, rsp_data, rsp_err, unit_start, unit_x);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== 8'h00 || rsp_err !== 1'b0 ||
            unit_start !== 1'b0 || unit_x !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_outputs: ready=%b rv=%b data=%h err=%b start=%b ux=%h want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, unit_start, unit_x);
        end
        @(negedge clk);
        req_valid  = '0;
        rst_n      = 1'b1;
        model_pend = 1'b0;
        unit_en    = 1'b1;
        model_ptr  = 0;
        act = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            spur_done = (k == 2);
            if (rsp_valid != '0 || unit_start) act++;
        end
        spur_done = 1'b0;
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: activity cycles=%0d want 0", act);
        end
        drive_slot();
        unit_delay = 0;
        for (int i = 0; i < N; i++) req_data[i] = x_t'(8'h60 + i);
        req_valid = '1;
        run_txn(1'b0, hs, rc, ls, lr, ux, rv, rd, re, vio, to);
        $display("post_reset: grant=%0d data=%h err=%b", hs, rd, re);
        checks++;
        if (to || hs !== model_pick(4'b1111, model_ptr) || rd !== 8'h9F || re !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first: grant=%0d data=%h err=%b want 0 9f 0", hs, rd, re);
        end
        drive_slot();
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_single();
        test_timeout();
        test_done_at_timeout();
        test_spurious_done();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
